// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core
// Multi-cycle RV32I-subset core. Each instruction steps through a
// FETCH/DECODE/EXEC/MEM/WB state machine, so one ALU and one port per memory
// are reused on every cycle. Contains a loadable instruction ROM, a data RAM,
// the register file and the PC.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (memories keep their contents)
//   imem_we    instruction-memory load strobe (any state)
//   imem_addr  instruction word address for the load
//   imem_wdata instruction word for the load
//   pc         current program counter (byte address)
//   state      FSM state code (FETCH=0 .. HALT=5)
//   wb_valid   one-cycle pulse when a register write commits
//   wb_rd      destination register of the last commit
//   wb_data    value of the last commit
//   halted     core stopped on an illegal opcode, ECALL or EBREAK
module riscv_multicycle_core #(
    parameter int          WIDTH      = 32,
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic [WIDTH-1:0]              pc,
    output logic [2:0]                    state,
    output logic                          wb_valid,
    output logic [4:0]                    wb_rd,
    output logic [WIDTH-1:0]              wb_data,
    output logic                          halted
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      imem [IMEM_DEPTH];
    logic [31:0]      dmem [DMEM_DEPTH];
    logic [WIDTH-1:0] rf   [32];

    logic [WIDTH-1:0] pc_q, a_q, b_q, alu_out_q, mdr_q;
    logic [31:0]      ir_q;

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
        return WIDTH'($signed(v));
    endfunction

    wire [6:0] opcode = ir_q[6:0];
    wire [4:0] rd     = ir_q[11:7];
    wire [2:0] funct3 = ir_q[14:12];
    wire [4:0] rs1    = ir_q[19:15];
    wire [4:0] rs2    = ir_q[24:20];
    wire [6:0] funct7 = ir_q[31:25];

    logic [WIDTH-1:0] imm, op_b, alu_res, wb_val, jalr_sum;
    logic [4:0]       shamt;
    logic             legal, taken;

    // Immediate selection; IR is stable from DECODE through WB.
    always_comb begin
        case (opcode)
            OP_STORE:  imm = sext32({{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]});
            OP_BRANCH: imm = sext32({{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0});
            OP_LUI:    imm = sext32({ir_q[31:12], 12'b0});
            OP_JAL:    imm = sext32({{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0});
            default:   imm = sext32({{20{ir_q[31]}}, ir_q[31:20]});
        endcase
    end

    assign op_b     = (opcode == OP_OP) ? b_q : imm;
    assign shamt    = op_b[4:0];
    assign jalr_sum = a_q + imm;
    assign wb_val   = (opcode == OP_LOAD) ? mdr_q : alu_out_q;

    // Only encodings of the supported subset are legal; SYSTEM (ECALL/EBREAK)
    // and everything else falls through to HALT.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_OP:     legal = (funct7 == 7'b0) ||
                               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            OP_IMM:    legal = (funct3 == 3'b001) ? (funct7 == 7'b0) :
                               (funct3 == 3'b101) ? (funct7 == 7'b0 || funct7 == 7'b0100000) : 1'b1;
            OP_LUI:    legal = 1'b1;
            OP_JAL:    legal = 1'b1;
            OP_JALR:   legal = (funct3 == 3'b000);
            OP_LOAD:   legal = (funct3 == 3'b010);
            OP_STORE:  legal = (funct3 == 3'b010);
            OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_LUI:            alu_res = imm;
            OP_JAL, OP_JALR:   alu_res = pc_q + WIDTH'(4);
            OP_LOAD, OP_STORE: alu_res = a_q + imm;
            default: begin
                case (funct3)
                    3'b000: alu_res = (opcode == OP_OP && ir_q[30]) ? a_q - op_b : a_q + op_b;
                    3'b001: alu_res = a_q << shamt;
                    3'b010: alu_res = ($signed(a_q) < $signed(op_b)) ? WIDTH'(1) : '0;
                    3'b011: alu_res = (a_q < op_b) ? WIDTH'(1) : '0;
                    3'b100: alu_res = a_q ^ op_b;
                    3'b101: alu_res = ir_q[30] ? $unsigned($signed(a_q) >>> shamt) : a_q >> shamt;
                    3'b110: alu_res = a_q | op_b;
                    default: alu_res = a_q & op_b;
                endcase
            end
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = (a_q == b_q);
            3'b001: taken = (a_q != b_q);
            3'b100: taken = ($signed(a_q) < $signed(b_q));
            3'b101: taken = !($signed(a_q) < $signed(b_q));
            3'b110: taken = (a_q < b_q);
            3'b111: taken = !(a_q < b_q);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM;
                else if (opcode == OP_BRANCH)                state_d = S_FETCH;
                else                                         state_d = S_WB;
            end
            S_MEM:    state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= WIDTH'(RESET_PC);
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state_q  <= state_d;
            wb_valid <= 1'b0;
            case (state_q)
                S_FETCH:  ir_q <= imem[pc_q[IA+1:2]];
                S_DECODE: begin
                    a_q <= (rs1 == 5'd0) ? '0 : rf[rs1];
                    b_q <= (rs2 == 5'd0) ? '0 : rf[rs2];
                end
                S_EXEC: begin
                    alu_out_q <= alu_res;
                    if (opcode == OP_BRANCH) pc_q <= taken ? pc_q + imm : pc_q + WIDTH'(4);
                    else if (opcode == OP_JAL) pc_q <= pc_q + imm;
                    else if (opcode == OP_JALR) pc_q <= {jalr_sum[WIDTH-1:1], 1'b0};
                end
                S_MEM: begin
                    if (opcode == OP_LOAD) mdr_q <= sext32(dmem[alu_out_q[DA+1:2]]);
                    else pc_q <= pc_q + WIDTH'(4);
                end
                S_WB: begin
                    if (rd != 5'd0) rf[rd] <= wb_val;
                    wb_valid <= 1'b1;
                    wb_rd    <= rd;
                    wb_data  <= wb_val;
                    if (opcode != OP_JAL && opcode != OP_JALR) pc_q <= pc_q + WIDTH'(4);
                end
                default: ;
            endcase
        end
    end

    // Memories are not reset; the store is additionally gated by rst so an
    // aborted SW can never land.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_MEM && opcode == OP_STORE)
            dmem[alu_out_q[DA+1:2]] <= b_q[31:0];
    end

    assign pc     = pc_q;
    assign state  = state_q;
    assign halted = (state_q == S_HALT);
endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
- Parametrised multi-cycle RV32I-subset core; successor to the single-cycle top.
- Splits each instruction across a FETCH/DECODE/EXEC/MEM/WB state machine, so one ALU and one memory port per array are shared across cycles.
- Contains its own instruction ROM (loadable), data RAM, register file and PC. Exposes writeback and status for the bench.

Parameters:
- WIDTH, 32, datapath/register width; must be >= 32. Immediates are sign-extended to WIDTH.
- IMEM_DEPTH, 256, instruction words (power of 2).
- DMEM_DEPTH, 256, data words (power of 2).
- RESET_PC, 0, PC value after reset (byte address, word aligned).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_we  in  1  load strobe for instruction memory.
- imem_addr  in  log2(IMEM_DEPTH)  word address for load.
- imem_wdata  in  32  instruction word for load.
- pc  out  WIDTH  current PC.
- state  out  3  FSM state code.
- wb_valid  out  1  one-cycle pulse when a register write commits.
- wb_rd  out  5  destination register of the commit.
- wb_data  out  WIDTH  value written (rd output of the core).
- halted  out  1  core stopped.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; state=FETCH; wb_valid=0; wb_rd=0; wb_data=0; halted=0.
  - x1..x31 = 0; IR/A/B/ALUOut/MDR = 0.
  - IMEM and DMEM contents are retained.
- IMEM load:
  - imem_we writes IMEM[imem_addr] on the clk edge, independent of state.
  - Intended use is while rst=1 or halted=1.
- Memory addressing:
  - IMEM index = pc[log2(IMEM_DEPTH)+1:2]; DMEM index = addr[log2(DMEM_DEPTH)+1:2]. Both wrap modulo depth.
  - Addr bits [1:0] are ignored (word access only).
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - IR <= IMEM[pc]; go to DECODE.
- DECODE:
  - A <= x[rs1], B <= x[rs2] (x0 reads 0); immediate generated from IR.
  - Illegal/unsupported opcode, ECALL or EBREAK -> HALT.
  - Otherwise -> EXEC.
- EXEC:
  - OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is B[4:0]. -> WB.
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. -> WB.
  - LUI: ALUOut = imm<<12, sign-extended. -> WB.
  - LOAD LW / STORE SW: ALUOut = A + imm. -> MEM.
  - BRANCH BEQ/BNE/BLT/BGE/BLTU/BGEU:
    - taken: pc <= pc + imm; not taken: pc <= pc + 4.
    - -> FETCH. No writeback; 3 cycles total.
  - JAL: ALUOut = pc + 4; pc <= pc + imm. -> WB.
  - JALR: ALUOut = pc + 4; pc <= (A + imm) & ~1. -> WB.
  - All arithmetic is modulo 2^WIDTH.
- MEM:
  - LW: MDR <= DMEM[ALUOut]; -> WB.
  - SW: DMEM[ALUOut] <= B[31:0]; pc <= pc + 4; -> FETCH.
- WB:
  - x[rd] <= (LW ? MDR : ALUOut) unless rd = 0.
  - wb_valid=1, wb_rd=rd, wb_data=written value for exactly this cycle.
  - wb_valid also pulses when rd=0; in that case the register is not written.
  - pc <= pc + 4, except JAL/JALR which already updated pc. -> FETCH.
- Cycle counts per instruction:
  - ALU/LUI/JAL/JALR: 4.
  - LW: 5.
  - SW: 4.
  - Branch: 3.
- HALT:
  - halted=1; pc frozen at the address of the offending instruction.
  - No register or memory writes. Exit only via rst.
- Reset mid-instruction:
  - Any state aborts immediately.
  - No partial register or DMEM write occurs after rst rises.
- wb_data and wb_rd hold their last values when wb_valid=0.

Test Plan:
- Load "ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; EBREAK" and release rst:
  - wb pulses (1,5), (2,0xFFFFFFFD), (3,2) at cycles 4, 8, 12 after reset release.
  - halted=1 with pc=0xC.
- SUB/SRA/SLTU with x1=0x80000000 and x2=1:
  - SUB gives 0x7FFFFFFF; SRA by 1 gives 0xC0000000; SLTU x1<x2 gives 0.
- "ADDI x1,x0,0x55; SW x1,8(x0); LW x4,8(x0)":
  - SW produces no wb pulse.
  - LW commits (4,0x55) five cycles after its FETCH.
- Loop "ADDI x1,x0,3; ADDI x1,x1,-1; BNE x1,x0,-4; EBREAK":
  - x1 commits 3, 2, 1, 0; BNE is taken twice.
  - Final pc=0xC, halted=1.
- "ADDI x0,x0,7":
  - wb_valid pulses with wb_rd=0 and wb_data=7.
  - A subsequent "ADD x5,x0,x0" commits 0.
- Assert rst during the MEM state of a SW:
  - DMEM word unchanged; pc=RESET_PC; state=0 immediately (asynchronous); all registers 0.
